// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage sitting between EX/MEM and MEM/WB.
//   Non-memory ops pass straight to MEM/WB with one cycle of latency. Aligned loads and stores
//   run a req/ack handshake on the data-memory port. The stage stalls upstream until the
//   handshake ends, either by ack or by the TIMEOUT abort. Misaligned ops and flushed ops
//   leave a bubble.
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   in_*                - instruction from EX/MEM (held by upstream while stall=1)
//   flush               - kill the instruction currently held in the stage
//   dmem_*              - registered word-aligned data-memory request, plus rdata/ack returns
//   wb_valid..writereg  - registered MEM/WB outputs
//   stall               - combinational back-pressure to upstream
//   misaligned, timeout_err - one-cycle error pulses
//   load_count, store_count - acked access counters (wrap)
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic        in_memtoreg,
  input  logic        in_regwrite,
  input  logic [4:0]  in_writereg,
  input  logic [31:0] in_aluout,
  input  logic [31:0] in_writedata,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] readdata,
  output logic [31:0] ULAout,
  output logic        memtoreg,
  output logic        regwrite,
  output logic [4:0]  writereg,
  output logic        stall,
  output logic        misaligned,
  output logic        timeout_err,
  output logic [31:0] load_count,
  output logic [31:0] store_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          killed_q, killed_d;
  // Instruction fields captured at start, used when the access completes.
  logic [1:0]    l_size_q, l_size_d;
  logic          l_unsigned_q, l_unsigned_d;
  logic [1:0]    l_off_q, l_off_d;
  logic          l_memtoreg_q, l_memtoreg_d;
  logic          l_regwrite_q, l_regwrite_d;
  logic [4:0]    l_writereg_q, l_writereg_d;
  logic [31:0]   l_aluout_q, l_aluout_d;

  logic          req_d, we_d, wb_valid_d, memtoreg_d, regwrite_d, mis_d, to_d;
  logic [31:0]   addr_d, wdata_d, readdata_d, ula_d, lc_d, sc_d;
  logic [3:0]    be_d;
  logic [4:0]    writereg_d;

  logic          is_mem, aligned, start;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc, load_data;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  assign is_mem = in_memread | in_memwrite;
  assign start  = (state_q == StIdle) & in_valid & is_mem & ~flush & aligned;
  assign stall  = ((state_q == StIdle) & start) | ((state_q == StBusy) & ~dmem_ack);

  always_comb begin
    aligned    = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = in_writedata;
    unique case (in_size)
      2'b00: begin
        aligned    = 1'b1;
        be_calc    = 4'b0001 << in_aluout[1:0];
        wdata_calc = {4{in_writedata[7:0]}};
      end
      2'b01: begin
        aligned    = ~in_aluout[0];
        be_calc    = 4'b0011 << in_aluout[1:0];
        wdata_calc = {2{in_writedata[15:0]}};
      end
      2'b10:   aligned = (in_aluout[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Lane selection and extension of the returned word.
  always_comb begin
    sel_half = l_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (l_off_q)
      2'd0:    sel_byte = dmem_rdata[7:0];
      2'd1:    sel_byte = dmem_rdata[15:8];
      2'd2:    sel_byte = dmem_rdata[23:16];
      default: sel_byte = dmem_rdata[31:24];
    endcase
    unique case (l_size_q)
      2'b00:   load_data = {{24{~l_unsigned_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_data = {{16{~l_unsigned_q & sel_half[15]}}, sel_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    killed_d     = killed_q;
    l_size_d     = l_size_q;
    l_unsigned_d = l_unsigned_q;
    l_off_d      = l_off_q;
    l_memtoreg_d = l_memtoreg_q;
    l_regwrite_d = l_regwrite_q;
    l_writereg_d = l_writereg_q;
    l_aluout_d   = l_aluout_q;
    req_d        = dmem_req;
    we_d         = dmem_we;
    addr_d       = dmem_addr;
    be_d         = dmem_be;
    wdata_d      = dmem_wdata;
    // MEM/WB defaults to a bubble every cycle unless something completes.
    wb_valid_d   = 1'b0;
    regwrite_d   = 1'b0;
    memtoreg_d   = memtoreg;
    readdata_d   = readdata;
    ula_d        = ULAout;
    writereg_d   = writereg;
    mis_d        = 1'b0;
    to_d         = 1'b0;
    lc_d         = load_count;
    sc_d         = store_count;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            regwrite_d = in_regwrite;
            memtoreg_d = in_memtoreg;
            readdata_d = 32'd0;
            ula_d      = in_aluout;
            writereg_d = in_writereg;
          end else if (!aligned) begin
            mis_d = 1'b1;
          end else begin
            state_d      = StBusy;
            tcnt_d       = '0;
            killed_d     = 1'b0;
            req_d        = 1'b1;
            we_d         = in_memwrite;
            addr_d       = {in_aluout[31:2], 2'b00};
            be_d         = be_calc;
            wdata_d      = wdata_calc;
            l_size_d     = in_size;
            l_unsigned_d = in_unsigned;
            l_off_d      = in_aluout[1:0];
            l_memtoreg_d = in_memtoreg;
            l_regwrite_d = in_regwrite;
            l_writereg_d = in_writereg;
            l_aluout_d   = in_aluout;
          end
        end
      end
      StBusy: begin
        if (flush) killed_d = 1'b1;
        if (dmem_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          // A killed access still completed on the bus, so it is still counted.
          if (dmem_we) sc_d = store_count + 32'd1;
          else         lc_d = load_count + 32'd1;
          if (!killed_q && !flush) begin
            wb_valid_d = 1'b1;
            regwrite_d = dmem_we ? 1'b0 : l_regwrite_q;
            readdata_d = dmem_we ? 32'd0 : load_data;
            memtoreg_d = l_memtoreg_q;
            ula_d      = l_aluout_q;
            writereg_d = l_writereg_q;
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = StIdle;
          req_d   = 1'b0;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      tcnt_q       <= '0;
      killed_q     <= 1'b0;
      l_size_q     <= 2'b00;
      l_unsigned_q <= 1'b0;
      l_off_q      <= 2'b00;
      l_memtoreg_q <= 1'b0;
      l_regwrite_q <= 1'b0;
      l_writereg_q <= 5'd0;
      l_aluout_q   <= 32'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_be      <= 4'd0;
      dmem_wdata   <= 32'd0;
      wb_valid     <= 1'b0;
      readdata     <= 32'd0;
      ULAout       <= 32'd0;
      memtoreg     <= 1'b0;
      regwrite     <= 1'b0;
      writereg     <= 5'd0;
      misaligned   <= 1'b0;
      timeout_err  <= 1'b0;
      load_count   <= 32'd0;
      store_count  <= 32'd0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      killed_q     <= killed_d;
      l_size_q     <= l_size_d;
      l_unsigned_q <= l_unsigned_d;
      l_off_q      <= l_off_d;
      l_memtoreg_q <= l_memtoreg_d;
      l_regwrite_q <= l_regwrite_d;
      l_writereg_q <= l_writereg_d;
      l_aluout_q   <= l_aluout_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_be      <= be_d;
      dmem_wdata   <= wdata_d;
      wb_valid     <= wb_valid_d;
      readdata     <= readdata_d;
      ULAout       <= ula_d;
      memtoreg     <= memtoreg_d;
      regwrite     <= regwrite_d;
      writereg     <= writereg_d;
      misaligned   <= mis_d;
      timeout_err  <= to_d;
      load_count   <= lc_d;
      store_count  <= sc_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, lb/sh/lhu handshakes, misaligned op,
// idle ack, flush in idle and busy, timeout abort and reset during busy.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_memread, in_memwrite, in_unsigned, in_memtoreg, in_regwrite;
  logic [1:0]  in_size;
  logic [4:0]  in_writereg;
  logic [31:0] in_aluout, in_writedata;
  logic        flush;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, memtoreg, regwrite, stall, misaligned, timeout_err;
  logic [31:0] readdata, ULAout, load_count, store_count;
  logic [4:0]  writereg;

  int vectors = 0;
  int errors  = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_memread  (in_memread),
    .in_memwrite (in_memwrite),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .in_memtoreg (in_memtoreg),
    .in_regwrite (in_regwrite),
    .in_writereg (in_writereg),
    .in_aluout   (in_aluout),
    .in_writedata(in_writedata),
    .flush       (flush),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .wb_valid    (wb_valid),
    .readdata    (readdata),
    .ULAout      (ULAout),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .writereg    (writereg),
    .stall       (stall),
    .misaligned  (misaligned),
    .timeout_err (timeout_err),
    .load_count  (load_count),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    in_valid     = 1'b1;
    in_memread   = rd;
    in_memwrite  = wr;
    in_size      = sz;
    in_unsigned  = uns;
    in_aluout    = addr;
    in_writedata = wd;
    in_memtoreg  = rd;
    in_regwrite  = ~wr;
    in_writereg  = 5'd7;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_memread = 0; in_memwrite = 0; in_size = 0; in_unsigned = 0;
    in_memtoreg = 0; in_regwrite = 0; in_writereg = 0; in_aluout = 0; in_writedata = 0;
    flush = 0; dmem_rdata = 0; dmem_ack = 0;
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_load_count", load_count, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;

    // ALU op passes through with latency 1 and no stall.
    set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0);
    in_regwrite = 1'b1; in_writereg = 5'd5;
    #1 chk("alu_stall", 32'(stall), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_ulaout", ULAout, 32'h0000_1234);
    chk("alu_writereg", 32'(writereg), 32'd5);
    chk("alu_regwrite", 32'(regwrite), 32'd1);

    // lb at 0x103, ack two cycles after req appears.
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
    #1 chk("lb_stall_c0", 32'(stall), 32'd1);
    tick();
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_be", 32'(dmem_be), 32'h8);
    chk("lb_stall_c1", 32'(stall), 32'd1);
    tick();
    chk("lb_stall_c2", 32'(stall), 32'd1);
    chk("lb_wb_bubble", 32'(wb_valid), 32'd0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    #1 chk("lb_stall_ack", 32'(stall), 32'd0);
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0;
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_readdata", readdata, 32'hFFFF_FF80);
    chk("lb_load_count", load_count, 32'd1);
    chk("lb_req_drop", 32'(dmem_req), 32'd0);

    // sh at 0x102, acked in the first busy cycle.
    set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'hABCD_1234);
    tick();
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_addr", dmem_addr, 32'h0000_0100);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0;
    chk("sh_store_count", store_count, 32'd1);
    chk("sh_regwrite", 32'(regwrite), 32'd0);
    chk("sh_readdata", readdata, 32'd0);
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);

    // Misaligned lw at 0x101.
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
    #1 chk("mis_stall", 32'(stall), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(misaligned), 32'd0);
    chk("mis_load_count", load_count, 32'd1);

    // Ack while idle is ignored.
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_count", load_count, 32'd1);
    chk("idle_ack_wb", 32'(wb_valid), 32'd0);

    // Flush in idle: bubble, no request.
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    flush = 1'b1;
    #1 chk("fli_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fli_req", 32'(dmem_req), 32'd0);
    chk("fli_wb_valid", 32'(wb_valid), 32'd0);

    // Timeout: lw never acked.
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    tick();
    chk("to_req_c1", 32'(dmem_req), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    chk("to_req_c16", 32'(dmem_req), 32'd1);
    chk("to_err_early", 32'(timeout_err), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_err_pulse", 32'(timeout_err), 32'd1);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_load_count", load_count, 32'd1);
    tick();
    chk("to_err_end", 32'(timeout_err), 32'd0);

    // Flush during busy, then ack: bubble but counted.
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0;
    chk("flb_wb_valid", 32'(wb_valid), 32'd0);
    chk("flb_regwrite", 32'(regwrite), 32'd0);
    chk("flb_load_count", load_count, 32'd2);

    // Reset during busy.
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
    tick();
    chk("rb_req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_req", 32'(dmem_req), 32'd0);
    chk("rb_load_count", load_count, 32'd0);
    chk("rb_store_count", store_count, 32'd0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    tick();
    chk("rb_req_after", 32'(dmem_req), 32'd0);
    chk("rb_stall_after", 32'(stall), 32'd0);

    // lhu at 0x406: upper half, zero-extended.
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0406, 32'h0);
    tick();
    chk("lhu_be", 32'(dmem_be), 32'hC);
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_5555;
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0;
    chk("lhu_readdata", readdata, 32'h0000_8001);
    chk("lhu_load_count", load_count, 32'd1);

    // lh at 0x400: lower half, sign-extended.
    set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0400, 32'h0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_F00D;
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0;
    chk("lh_readdata", readdata, 32'hFFFF_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles in BUSY without dmem_ack before abort.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have inputs from EX/MEM: in_valid 1, in_memread 1, in_memwrite 1, in_size 2 (00 byte, 01 half, 10 word), in_unsigned 1, in_memtoreg 1, in_regwrite 1, in_writereg 5, in_aluout 32 (address or ALU result), in_writedata 32.
REQ-005 SHALL have input flush 1, which kills the instruction currently held in the stage.
REQ-006 SHALL have data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32 (word-aligned, bits [1:0]=0), dmem_be out 4, dmem_wdata out 32, dmem_rdata in 32, dmem_ack in 1.
REQ-007 SHALL have MEM/WB outputs: wb_valid out 1, readdata out 32, ULAout out 32, memtoreg out 1, regwrite out 1, writereg out 5.
REQ-008 SHALL have status outputs: stall out 1, misaligned out 1 (one-cycle pulse), timeout_err out 1 (one-cycle pulse), load_count out 32, store_count out 32.

Function
REQ-009 SHALL implement the FSM states IDLE and BUSY.
REQ-010 Start condition: state IDLE, in_valid=1, in_memread or in_memwrite, flush=0, address aligned.
REQ-011 Alignment rules: half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned; in_size=11 is treated as misaligned.
REQ-012 Non-memory op in IDLE: on the next edge, register the inputs into the MEM/WB outputs with wb_valid=1 and readdata=0 (latency 1, no stall).
REQ-013 On a start condition: go to BUSY; from the next cycle, register dmem_req=1, dmem_we=in_memwrite, dmem_addr={addr[31:2],2'b00}, and the byte enables and data.
REQ-014 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
REQ-015 Write data: byte replicated 4 times; half replicated twice; word as-is.
REQ-016 In BUSY: hold all dmem_* outputs stable until dmem_ack is sampled high.
REQ-017 On ack, at that edge: deassert dmem_req, return to IDLE, and write the MEM/WB outputs with wb_valid=1.
REQ-018 Load extraction: select the byte or half by addr[1:0]; zero-extend if in_unsigned=1, else sign-extend; write the result to readdata. Stores SHALL set readdata=0 and regwrite=0.
REQ-019 stall: combinational, equal to (IDLE and start condition) or (BUSY and not dmem_ack). Upstream SHALL hold its inputs while stall=1.
REQ-020 While stall=1 or a misaligned/flush bubble occurs, the MEM/WB outputs SHALL be a bubble: wb_valid=0, regwrite=0.
REQ-021 Misaligned memory op in IDLE with in_valid=1: issue no request, pulse misaligned=1 for one cycle, emit a bubble, and leave the counters unchanged.
REQ-022 Flush in IDLE: emit a bubble and issue no request.
REQ-023 Flush in BUSY: do not abort the handshake; set an internal killed flag. On ack, emit a bubble, and still increment the counters if the access completed.
REQ-024 Timeout: count cycles in BUSY. If the count reaches TIMEOUT without ack: drop dmem_req, return to IDLE, pulse timeout_err, emit a bubble, leave the counters unchanged.
REQ-025 load_count and store_count SHALL increment by 1 on each acked load or store, and wrap modulo 2^32.
REQ-026 dmem_ack while in IDLE SHALL be ignored.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, all MEM/WB outputs=0, misaligned=0, timeout_err=0, both counters=0, timeout counter=0, killed flag=0.
REQ-028 Reset during BUSY SHALL abandon the access immediately; no counter update and no MEM/WB write.

Verification
REQ-029 ALU op: aluout=0x0000_1234, regwrite=1, writereg=5 -> next cycle wb_valid=1, ULAout=0x1234, stall never high.
REQ-030 lb: addr=0x103, unsigned=0, ack 2 cycles after req, rdata=0x80FF_FFFF -> readdata=0xFFFF_FF80, stall high for 3 cycles, load_count=1.
REQ-031 sh: addr=0x102, wdata=0xABCD_1234 -> dmem_be=1100, dmem_wdata=0x1234_1234, dmem_addr=0x100, store_count=1, regwrite=0.
REQ-032 lw at addr=0x101 -> misaligned pulses once, dmem_req stays 0, wb_valid=0.
REQ-033 lw with ack never asserted, TIMEOUT=16 -> dmem_req drops after 16 BUSY cycles, timeout_err pulses, stall falls.
REQ-034 lw with flush in BUSY, then ack -> wb_valid=0, load_count increments; separately, reset asserted in BUSY -> dmem_req=0 immediately, counters=0.
